popcount_seq: RTL and testbench

POPCOUNT_SEQ -- requirements
Module: popcount_seq

---
 rtl/popcount_seq.sv | 147 ++++++++++++++
 tb/tb_popcount_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/popcount_seq.sv
// rtl/popcount_seq.sv - sequential lane-by-lane popcount with saturating accumulator
module popcount_seq #(
    parameter  int DATA_W = 16,
    parameter  int LANE_W = 4,
    parameter  int TOT_W  = 8,
    localparam int NLANES = DATA_W / LANE_W,
    localparam int CNT_W  = $clog2(DATA_W + 1),
    localparam int SEL_W  = $clog2(NLANES)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_lane_mode,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic              i_acc,
    input  logic              i_clr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CNT_W-1:0]  o_count,
    output logic [TOT_W-1:0]  o_total
);

    // Wide enough to hold total + count without wrapping before the saturation test
    localparam int SUM_W = ((TOT_W > CNT_W) ? TOT_W : CNT_W) + 1;
    localparam logic [TOT_W-1:0] TOT_MAX  = {TOT_W{1'b1}};
    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(NLANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                mode_q, mode_d;
    logic                acc_q, acc_d;
    logic [SEL_W-1:0]    lane_q, lane_d;
    logic [CNT_W-1:0]    part_q, part_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [TOT_W-1:0]    total_q, total_d;

    logic [LANE_W-1:0]   lanes [NLANES];
    logic [LANE_W-1:0]   lane_bits;
    logic [CNT_W-1:0]    lane_pop;
    logic [CNT_W-1:0]    part_sum;
    logic [SUM_W-1:0]    acc_sum;

    // Split the captured word into lanes so the active one is a plain array lookup
    always_comb begin
        for (int k = 0; k < NLANES; k++) begin
            lanes[k] = data_q[k*LANE_W +: LANE_W];
        end
    end

    // Popcount of the lane currently addressed by the lane index
    always_comb begin
        lane_bits = lanes[lane_q];
        lane_pop  = '0;
        for (int b = 0; b < LANE_W; b++) begin
            lane_pop = lane_pop + CNT_W'(lane_bits[b]);
        end
        part_sum = part_q + lane_pop;
        acc_sum  = SUM_W'(total_q) + SUM_W'(count_q);
    end

    // Next-state logic: capture in IDLE, walk lanes in COUNT, hand off in DONE
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        lane_d  = lane_q;
        part_d  = part_q;
        count_d = count_q;
        total_d = total_q;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    data_d  = i_data;
                    mode_d  = i_lane_mode;
                    acc_d   = i_acc;
                    part_d  = '0;
                    lane_d  = i_lane_mode ? i_sel : '0;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                part_d = part_sum;
                if (mode_q || (lane_q == LAST_LANE)) begin
                    count_d = part_sum;
                    state_d = ST_DONE;
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_d = ST_IDLE;
                    if (acc_q) begin
                        total_d = (acc_sum > SUM_W'(TOT_MAX)) ? TOT_MAX : TOT_W'(acc_sum);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear overrides any accumulation landing on the same edge
        if (i_clr) begin
            total_d = '0;
        end
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            mode_q  <= 1'b0;
            acc_q   <= 1'b0;
            lane_q  <= '0;
            part_q  <= '0;
            count_q <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            lane_q  <= lane_d;
            part_q  <= part_d;
            count_q <= count_d;
            total_q <= total_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_count = count_q;
    assign o_total = total_q;

endmodule

// File: tb/tb_popcount_seq.sv
// tb/tb_popcount_seq.sv - self-checking bench for popcount_seq
module tb_popcount_seq;

    localparam int DATA_W = 16;
    localparam int LANE_W = 4;
    localparam int TOT_W  = 8;
    localparam int NLANES = DATA_W / LANE_W;
    localparam int CNT_W  = 5;
    localparam int SEL_W  = 2;
    localparam int TOT_MAX = 255;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic              i_lane_mode;
    logic [SEL_W-1:0]  i_sel;
    logic              i_acc;
    logic              i_clr;
    logic              o_valid;
    logic              i_ready;
    logic [CNT_W-1:0]  o_count;
    logic [TOT_W-1:0]  o_total;

    int checks   = 0;
    int failures = 0;
    int model_total = 0;

    popcount_seq #(.DATA_W(DATA_W), .LANE_W(LANE_W), .TOT_W(TOT_W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .i_lane_mode (i_lane_mode),
        .i_sel       (i_sel),
        .i_acc       (i_acc),
        .i_clr       (i_clr),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_count     (o_count),
        .o_total     (o_total)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int ref_count(input logic [DATA_W-1:0] d, input logic m, input int s);
        logic [DATA_W-1:0] v;
        v = m ? ((d >> (s * LANE_W)) & ((1 << LANE_W) - 1)) : d;
        return $countones(v);
    endfunction

    // One complete transaction: accept, count, optional stall, handshake
    task automatic run_word(input logic [DATA_W-1:0] d, input logic m, input logic [SEL_W-1:0] s,
                            input logic a, input int stall, input logic clr_hs, input logic valid_hs);
        int exp_cnt;
        int exp_lat;
        int lat;
        exp_cnt = ref_count(d, m, int'(s));
        exp_lat = m ? 1 : NLANES;
        chk("ready_before_accept", o_ready, 1);
        i_valid = 1'b1; i_data = d; i_lane_mode = m; i_sel = s; i_acc = a;
        tick();
        i_valid = 1'b0;
        i_data = DATA_W'($urandom); i_sel = SEL_W'($urandom);
        i_lane_mode = 1'($urandom); i_acc = 1'($urandom);
        chk("ready_in_count", o_ready, 0);
        lat = 0;
        while (o_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("count", o_count, exp_cnt);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", o_valid, 1);
            chk("stall_ready", o_ready, 0);
            chk("stall_count", o_count, exp_cnt);
        end
        i_ready = 1'b1; i_clr = clr_hs; i_valid = valid_hs;
        tick();
        i_ready = 1'b0; i_clr = 1'b0; i_valid = 1'b0;
        if (clr_hs) model_total = 0;
        else if (a) model_total = (model_total + exp_cnt > TOT_MAX) ? TOT_MAX : model_total + exp_cnt;
        chk("ready_after_hs", o_ready, 1);
        chk("valid_after_hs", o_valid, 0);
        chk("total", o_total, model_total);
    endtask

    initial begin
        i_rst = 1'b0; i_valid = 1'b0; i_data = '0; i_lane_mode = 1'b0;
        i_sel = '0; i_acc = 1'b0; i_clr = 1'b0; i_ready = 1'b0;
        #1;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_total", o_total, 0);
        #22;
        i_rst = 1'b1;

        // Whole word and lane mode on the reference pattern
        run_word(16'h2344, 1'b0, 2'd0, 1'b1, 0, 1'b0, 1'b0);
        chk("whole_2344", o_total, 5);
        run_word(16'h2344, 1'b1, 2'd0, 1'b0, 0, 1'b0, 1'b0);
        run_word(16'h2344, 1'b1, 2'd2, 1'b0, 0, 1'b0, 1'b0);
        run_word(16'h2344, 1'b1, 2'd3, 1'b0, 0, 1'b0, 1'b0);

        // Back-pressure; i_valid held on the handshake edge must not start a new word
        run_word(16'hFFFF, 1'b0, 2'd1, 1'b0, 5, 1'b0, 1'b1);
        tick();
        chk("no_accept_on_hs", o_ready, 1);

        // Randomized traffic
        for (int n = 0; n < 20; n++) begin
            run_word(DATA_W'($urandom), 1'($urandom), SEL_W'($urandom), 1'($urandom),
                     int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        // Clear while idle
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        model_total = 0;
        chk("clr_idle", o_total, 0);

        // Saturation
        for (int n = 1; n <= 17; n++) begin
            run_word(16'hFFFF, 1'b0, 2'd0, 1'b1, 0, 1'b0, 1'b0);
            if (n == 15) chk("sat_15", o_total, 240);
            if (n == 16) chk("sat_16", o_total, 255);
            if (n == 17) chk("sat_17", o_total, 255);
        end
        run_word(16'hFFFF, 1'b0, 2'd0, 1'b1, 0, 1'b1, 1'b0);
        chk("clr_wins", o_total, 0);

        // Reset in the middle of COUNT at lane 2
        run_word(16'h00FF, 1'b0, 2'd0, 1'b1, 0, 1'b0, 1'b0);
        i_valid = 1'b1; i_data = 16'hFFFF; i_lane_mode = 1'b0; i_acc = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        #1;
        model_total = 0;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_ready", o_ready, 1);
        chk("midrst_count", o_count, 0);
        chk("midrst_total", o_total, 0);
        #2;
        i_rst = 1'b1;
        run_word(16'h000F, 1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b0);
        chk("fresh_000f", o_count, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
